integrate_dump: RTL and testbench

- Multi-channel, time-multiplexed integrate-and-dump accumulator with selectable wrap or saturate arithmetic.
- Samples arrive round-robin over `ch` channels. Each channel sums `len` of its own samples, then emits the sum with its channel index and an overflow flag, and restarts with no lost samples.
- Sits after ADC/filter front-ends as a decimating averager, and as a CIC-style first stage.

---
 rtl/sat_add.sv | 31 +++
 rtl/integrate_dump.sv | 101 ++++++++++
 tb/tb_integrate_dump.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sat_add.sv
// (m+1)-bit signed adder: widens an m-bit operand and an n-bit sample, flags
// signed overflow of the m-bit result and optionally clamps to min/max.
module sat_add #(
  parameter int n   = 16,
  parameter int m   = 24,
  parameter int sat = 0
) (
  input  logic signed [m-1:0] a,
  input  logic signed [n-1:0] b,
  output logic signed [m-1:0] res,
  output logic                ovf
);

  logic signed [m:0] ax;
  logic signed [m:0] bx;
  logic signed [m:0] sum;

  assign ax  = {a[m-1], a};
  assign bx  = {{(m+1-n){b[n-1]}}, b};
  assign sum = ax + bx;
  // One guard bit is enough: the top two bits disagree only when the m-bit result overflowed.
  assign ovf = sum[m] ^ sum[m-1];

  always_comb begin
    res = sum[m-1:0];
    if (ovf && (sat != 0)) begin
      res = sum[m] ? {1'b1, {(m-1){1'b0}}} : {1'b0, {(m-1){1'b1}}};
    end
  end

endmodule

// File: rtl/integrate_dump.sv
// Multi-channel time-multiplexed integrate-and-dump accumulator; each channel
// sums len of its own samples and emits the total with channel and overflow flag.
module integrate_dump #(
  parameter  int n   = 16,
  parameter  int m   = 24,
  parameter  int ch  = 4,
  parameter  int len = 256,
  parameter  int sat = 0,
  localparam int chw = (ch > 1) ? $clog2(ch) : 1,
  localparam int lw  = (len > 1) ? $clog2(len) : 1
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  sync,
  input  logic                  in_valid,
  input  logic signed [n-1:0]   in,
  output logic [chw-1:0]        ch_ptr,
  output logic                  out_valid,
  output logic signed [m-1:0]   out,
  output logic [chw-1:0]        out_ch,
  output logic                  out_ovf
);

  localparam logic [chw-1:0] plast = chw'(ch - 1);
  localparam logic [lw-1:0]  flast = lw'(len - 1);

  logic signed [m-1:0] acc [ch];
  logic [ch-1:0]       ovf;
  logic [lw-1:0]       fcnt;

  logic signed [m-1:0] cur;
  logic                cur_ovf;
  logic signed [m-1:0] res;
  logic                sovf;
  logic                dump;

  // Read port: select the accumulator owned by the channel of the incoming sample.
  always_comb begin
    cur     = '0;
    cur_ovf = 1'b0;
    for (int i = 0; i < ch; i++) begin
      if (ch_ptr == chw'(i)) begin
        cur     = acc[i];
        cur_ovf = ovf[i];
      end
    end
  end

  assign dump = in_valid && (fcnt == flast);

  sat_add #(
    .n   (n),
    .m   (m),
    .sat (sat)
  ) u_add (
    .a   (cur),
    .b   (in),
    .res (res),
    .ovf (sovf)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < ch; i++) acc[i] <= '0;
      ovf       <= '0;
      ch_ptr    <= '0;
      fcnt      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out_ch    <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sync) begin
        for (int i = 0; i < ch; i++) acc[i] <= '0;
        ovf    <= '0;
        ch_ptr <= '0;
        fcnt   <= '0;
      end else if (in_valid) begin
        ch_ptr <= (ch_ptr == plast) ? '0 : ch_ptr + 1'b1;
        if (ch_ptr == plast) begin
          fcnt <= (fcnt == flast) ? '0 : fcnt + 1'b1;
        end
        // A dumping channel restarts from zero so the next period loses no sample.
        for (int i = 0; i < ch; i++) begin
          if (ch_ptr == chw'(i)) begin
            acc[i] <= dump ? '0 : res;
            ovf[i] <= dump ? 1'b0 : (ovf[i] | sovf);
          end
        end
        if (dump) begin
          out       <= res;
          out_ch    <= ch_ptr;
          out_ovf   <= cur_ovf | sovf;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_integrate_dump.sv
// Scoreboard bench for integrate_dump: several parameterised instances, one
// active at a time, with expected dumps queued at stimulus time.
module tb_integrate_dump;

  localparam int SA = 0, SB = 1, SW = 2, SS = 3, SG = 4, SY = 5, SX = 6;

  typedef struct {
    int   val;
    int   chn;
    logic ovf;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               clr_n;
  logic               sync;
  logic               in_valid;
  logic signed [15:0] din;
  int                 sel;
  int                 cyc = 0;
  int                 checks = 0;
  int                 errors = 0;
  exp_t               q[$];
  exp_t               mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  logic iv_a, iv_b, iv_w, iv_s, iv_g, iv_y, iv_x;
  assign iv_a = in_valid && (sel == SA);
  assign iv_b = in_valid && (sel == SB);
  assign iv_w = in_valid && (sel == SW);
  assign iv_s = in_valid && (sel == SS);
  assign iv_g = in_valid && (sel == SG);
  assign iv_y = in_valid && (sel == SY);
  assign iv_x = in_valid && (sel == SX);

  logic [0:0] a_ptr, a_ch; logic a_vld, a_ovf; logic signed [23:0] a_out;
  logic [1:0] b_ptr, b_ch; logic b_vld, b_ovf; logic signed [23:0] b_out;
  logic [0:0] w_ptr, w_ch; logic w_vld, w_ovf; logic signed [7:0]  w_out;
  logic [0:0] s_ptr, s_ch; logic s_vld, s_ovf; logic signed [7:0]  s_out;
  logic [0:0] g_ptr, g_ch; logic g_vld, g_ovf; logic signed [23:0] g_out;
  logic [0:0] y_ptr, y_ch; logic y_vld, y_ovf; logic signed [23:0] y_out;
  logic [0:0] x_ptr, x_ch; logic x_vld, x_ovf; logic signed [16:0] x_out;

  integrate_dump #(.n(16), .m(24), .ch(1), .len(1), .sat(0)) u_a (
    .clk(clk), .clr_n(clr_n), .sync(sync), .in_valid(iv_a), .in(din),
    .ch_ptr(a_ptr), .out_valid(a_vld), .out(a_out), .out_ch(a_ch), .out_ovf(a_ovf));
  integrate_dump #(.n(16), .m(24), .ch(4), .len(3), .sat(0)) u_b (
    .clk(clk), .clr_n(clr_n), .sync(sync), .in_valid(iv_b), .in(din),
    .ch_ptr(b_ptr), .out_valid(b_vld), .out(b_out), .out_ch(b_ch), .out_ovf(b_ovf));
  integrate_dump #(.n(8), .m(8), .ch(1), .len(4), .sat(0)) u_w (
    .clk(clk), .clr_n(clr_n), .sync(sync), .in_valid(iv_w), .in(din[7:0]),
    .ch_ptr(w_ptr), .out_valid(w_vld), .out(w_out), .out_ch(w_ch), .out_ovf(w_ovf));
  integrate_dump #(.n(8), .m(8), .ch(1), .len(4), .sat(1)) u_s (
    .clk(clk), .clr_n(clr_n), .sync(sync), .in_valid(iv_s), .in(din[7:0]),
    .ch_ptr(s_ptr), .out_valid(s_vld), .out(s_out), .out_ch(s_ch), .out_ovf(s_ovf));
  integrate_dump #(.n(16), .m(24), .ch(2), .len(2), .sat(0)) u_g (
    .clk(clk), .clr_n(clr_n), .sync(sync), .in_valid(iv_g), .in(din),
    .ch_ptr(g_ptr), .out_valid(g_vld), .out(g_out), .out_ch(g_ch), .out_ovf(g_ovf));
  integrate_dump #(.n(16), .m(24), .ch(2), .len(4), .sat(0)) u_y (
    .clk(clk), .clr_n(clr_n), .sync(sync), .in_valid(iv_y), .in(din),
    .ch_ptr(y_ptr), .out_valid(y_vld), .out(y_out), .out_ch(y_ch), .out_ovf(y_ovf));
  integrate_dump #(.n(16), .m(17), .ch(1), .len(2), .sat(0)) u_x (
    .clk(clk), .clr_n(clr_n), .sync(sync), .in_valid(iv_x), .in(din),
    .ch_ptr(x_ptr), .out_valid(x_vld), .out(x_out), .out_ch(x_ch), .out_ovf(x_ovf));

  logic mon_valid, mon_ovf;
  int   mon_out, mon_ch;

  always_comb begin
    mon_valid = 1'b0;
    mon_out   = 0;
    mon_ch    = 0;
    mon_ovf   = 1'b0;
    case (sel)
      SA: begin mon_valid = a_vld; mon_out = 32'(a_out); mon_ch = 32'(a_ch); mon_ovf = a_ovf; end
      SB: begin mon_valid = b_vld; mon_out = 32'(b_out); mon_ch = 32'(b_ch); mon_ovf = b_ovf; end
      SW: begin mon_valid = w_vld; mon_out = 32'(w_out); mon_ch = 32'(w_ch); mon_ovf = w_ovf; end
      SS: begin mon_valid = s_vld; mon_out = 32'(s_out); mon_ch = 32'(s_ch); mon_ovf = s_ovf; end
      SG: begin mon_valid = g_vld; mon_out = 32'(g_out); mon_ch = 32'(g_ch); mon_ovf = g_ovf; end
      SY: begin mon_valid = y_vld; mon_out = 32'(y_out); mon_ch = 32'(y_ch); mon_ovf = y_ovf; end
      SX: begin mon_valid = x_vld; mon_out = 32'(x_out); mon_ch = 32'(x_ch); mon_ovf = x_ovf; end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (mon_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse sel=%0d: got out=%0d ch=%0d at cycle %0d, none expected",
                 sel, mon_out, mon_ch, cyc);
      end else begin
        mon_e = q.pop_front();
        checks += 4;
        if (mon_out !== mon_e.val) begin
          errors++;
          $display("FAIL out sel=%0d: got %0d, want %0d", sel, mon_out, mon_e.val);
        end
        if (mon_ch !== mon_e.chn) begin
          errors++;
          $display("FAIL out_ch sel=%0d: got %0d, want %0d", sel, mon_ch, mon_e.chn);
        end
        if (mon_ovf !== mon_e.ovf) begin
          errors++;
          $display("FAIL out_ovf sel=%0d: got %0b, want %0b", sel, mon_ovf, mon_e.ovf);
        end
        if (cyc !== mon_e.cyc) begin
          errors++;
          $display("FAIL latency sel=%0d: pulse at cycle %0d, want %0d", sel, cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic drive(input int v, input bit push, input int ev, input int ech, input bit eovf);
    exp_t e;
    din      = 16'(v);
    in_valid = 1'b1;
    if (push) begin
      e.val = ev; e.chn = ech; e.ovf = eovf; e.cyc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    repeat (3) idle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulses: %0d pending, want 0", name, q.size());
    end
    q.delete();
  endtask

  task automatic test_reset();
    checks += 10;
    if (a_vld !== 1'b0) begin errors++; $display("FAIL rst_a_vld: got %b, want 0", a_vld); end
    if (a_out !== '0)   begin errors++; $display("FAIL rst_a_out: got %0d, want 0", a_out); end
    if (a_ch !== '0)    begin errors++; $display("FAIL rst_a_ch: got %0d, want 0", a_ch); end
    if (a_ovf !== 1'b0) begin errors++; $display("FAIL rst_a_ovf: got %b, want 0", a_ovf); end
    if (a_ptr !== '0)   begin errors++; $display("FAIL rst_a_ptr: got %0d, want 0", a_ptr); end
    if (b_vld !== 1'b0) begin errors++; $display("FAIL rst_b_vld: got %b, want 0", b_vld); end
    if (b_out !== '0)   begin errors++; $display("FAIL rst_b_out: got %0d, want 0", b_out); end
    if (b_ch !== '0)    begin errors++; $display("FAIL rst_b_ch: got %0d, want 0", b_ch); end
    if (b_ovf !== 1'b0) begin errors++; $display("FAIL rst_b_ovf: got %b, want 0", b_ovf); end
    if (b_ptr !== '0)   begin errors++; $display("FAIL rst_b_ptr: got %0d, want 0", b_ptr); end
  endtask

  task automatic test_passthrough();
    sel = SA;
    drive(-5, 1'b1, -5, 0, 1'b0);
    drive(32767, 1'b1, 32767, 0, 1'b0);
    drain("passthrough");
    drive(7, 1'b0, 0, 0, 1'b0);
    checks++;
    if (a_vld !== 1'b1) begin errors++; $display("FAIL pre_reset_vld: got %b, want 1", a_vld); end
    clr_n = 1'b0;
    #1;
    checks += 2;
    if (a_vld !== 1'b0) begin errors++; $display("FAIL async_reset_vld: got %b, want 0", a_vld); end
    if (a_out !== '0)   begin errors++; $display("FAIL async_reset_out: got %0d, want 0", a_out); end
    @(posedge clk); #1;
    clr_n = 1'b1;
    drain("reset_mid");
  endtask

  task automatic test_multichannel();
    sel = SB;
    for (int i = 0; i < 12; i++) begin
      drive(10 * ((i % 4) + 1), i >= 8, 30 * ((i % 4) + 1), i % 4, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      drive(-((i % 4) + 1), i >= 8, -3 * ((i % 4) + 1), i % 4, 1'b0);
    end
    drain("multichannel");
  endtask

  task automatic test_wrap_sat();
    sel = SW;
    for (int i = 0; i < 4; i++) drive(100, i == 3, -112, 0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1, i == 3, 4, 0, 1'b0);
    drain("wrap");
    sel = SS;
    for (int i = 0; i < 4; i++) drive(100, i == 3, 127, 0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1, i == 3, 4, 0, 1'b0);
    drain("sat");
  endtask

  task automatic test_gapped();
    sel = SG;
    drive(1, 1'b0, 0, 0, 1'b0); idle();
    drive(2, 1'b0, 0, 0, 1'b0); idle();
    drive(3, 1'b1, 4, 0, 1'b0); idle();
    drive(4, 1'b1, 6, 1, 1'b0); idle();
    drain("gapped");
  endtask

  task automatic test_sync();
    sel = SY;
    for (int i = 0; i < 5; i++) drive(1, 1'b0, 0, 0, 1'b0);
    checks++;
    if (y_ptr !== 1'b1) begin errors++; $display("FAIL pre_sync_ptr: got %0d, want 1", y_ptr); end
    sync     = 1'b1;
    din      = 16'sd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    sync     = 1'b0;
    in_valid = 1'b0;
    checks += 2;
    if (y_vld !== 1'b0) begin errors++; $display("FAIL sync_vld: got %b, want 0", y_vld); end
    if (y_ptr !== 1'b0) begin errors++; $display("FAIL sync_ptr: got %0d, want 0", y_ptr); end
    for (int i = 0; i < 8; i++) drive(1, i >= 6, 4, i % 2, 1'b0);
    drain("sync");
  endtask

  task automatic test_neg_extreme();
    sel = SX;
    drive(-32768, 1'b0, 0, 0, 1'b0);
    drive(-32768, 1'b1, -65536, 0, 1'b0);
    drain("neg_extreme");
  endtask

  initial begin
    clr_n    = 1'b0;
    sync     = 1'b0;
    in_valid = 1'b0;
    din      = '0;
    sel      = SA;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    clr_n = 1'b1;
    idle();
    test_passthrough();
    test_multichannel();
    test_wrap_sat();
    test_gapped();
    test_sync();
    test_neg_extreme();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
